// File: rtl/timestamp_capture.sv
// timestamp_capture: samples the free-running counter on each rising edge of
// event_in and queues the samples in a small first-word-fall-through FIFO.
// A sticky overflow flag records events lost because the FIFO was full.
// A counter value of zero means the counter is idle, so events are ignored.
module timestamp_capture #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] counter,
  input  logic              event_in,
  output logic [DWIDTH-1:0] ts_data,
  output logic              ts_valid,
  input  logic              ts_ready,
  output logic [AW:0]       level,
  output logic              overflow,
  input  logic              ovf_clear
);

  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              event_q, event_d;
  logic              cap, pop, push, full, drop;

  // Edge detect, push/pop decisions and next-state computation.
  always_comb begin
    cap        = event_in & ~event_q & (counter != '0);
    full       = (level_q == LEVEL_FULL);
    pop        = (level_q != '0) & ts_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push       = cap & (~full | pop);
    drop       = cap & full & ~pop;
    event_d    = event_in;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    level_d    = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
    // A drop in the same cycle as a clear keeps the flag set.
    overflow_d = drop | (overflow_q & ~ovf_clear);
  end

  // Control state registers; reset discards all queued entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      event_q    <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      event_q    <= event_d;
    end
  end

  // Storage array; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= counter;
    end
  end

  // Head of queue is presented combinationally (first-word-fall-through).
  always_comb begin
    ts_valid = (level_q != '0);
    ts_data  = ts_valid ? mem_q[rd_ptr_q] : '0;
    level    = level_q;
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_timestamp_capture.sv
// Testbench for timestamp_capture: directed vector table, hand-written corner
// sequences, then randomized traffic checked against a queue-based model.
module tb_timestamp_capture;

  localparam int DW = 8;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] counter;
  logic          event_in;
  logic [DW-1:0] ts_data;
  logic          ts_valid;
  logic          ts_ready;
  logic [2:0]    level;
  logic          overflow;
  logic          ovf_clear;

  int checks = 0;
  int errors = 0;

  timestamp_capture #(.DWIDTH(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .counter   (counter),
    .event_in  (event_in),
    .ts_data   (ts_data),
    .ts_valid  (ts_valid),
    .ts_ready  (ts_ready),
    .level     (level),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of timestamps, previous event level, sticky flag.
  logic [DW-1:0] mq[$];
  bit            m_prev;
  bit            m_ovf;

  typedef struct {
    logic          ev;
    logic [DW-1:0] cnt;
    logic          rdy;
    logic          clr;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [2:0]    e_level;
    logic          e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ev, input logic [DW-1:0] cnt, input logic rdy,
                     input logic clr, input logic e_valid, input logic [DW-1:0] e_data,
                     input logic [2:0] e_level, input logic e_ovf);
    vec_t v;
    v.ev = ev; v.cnt = cnt; v.rdy = rdy; v.clr = clr;
    v.e_valid = e_valid; v.e_data = e_data; v.e_level = e_level; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_out(input string tag, input logic e_valid, input logic [DW-1:0] e_data,
                         input logic [2:0] e_level, input logic e_ovf);
    chk({tag, ".ts_valid"}, int'(ts_valid), int'(e_valid));
    chk({tag, ".ts_data"},  int'(ts_data),  int'(e_data));
    chk({tag, ".level"},    int'(level),    int'(e_level));
    chk({tag, ".overflow"}, int'(overflow), int'(e_ovf));
  endtask

  task automatic cmp_model(input string tag);
    logic [DW-1:0] head;
    head = (mq.size() != 0) ? mq[0] : '0;
    cmp_out(tag, mq.size() != 0, head, 3'(mq.size()), m_ovf);
  endtask

  // Apply one cycle of inputs, advance the model by the rules, sample after the edge.
  task automatic step(input logic ev, input logic [DW-1:0] cnt, input logic rdy, input logic clr);
    bit cap, pop, drop;
    int sz;
    event_in = ev; counter = cnt; ts_ready = rdy; ovf_clear = clr; rst = 1'b0;
    @(posedge clk);
    sz   = mq.size();
    cap  = ev && !m_prev && (cnt != 0);
    pop  = (sz != 0) && rdy;
    drop = cap && (sz == DP) && !pop;
    if (pop) void'(mq.pop_front());
    if (cap && !drop) mq.push_back(cnt);
    m_ovf  = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_prev = ev;
    #1;
  endtask

  task automatic do_reset(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      rst = 1'b1; event_in = i[0]; counter = 8'h33; ts_ready = 1'b1; ovf_clear = 1'b0;
      @(posedge clk);
      #1;
      mq.delete(); m_prev = 1'b0; m_ovf = 1'b0;
      cmp_out(tag, 1'b0, 8'h00, 3'd0, 1'b0);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; counter = '0; event_in = 1'b0; ts_ready = 1'b0; ovf_clear = 1'b0;

    // Directed table: ev, cnt, rdy, clr -> valid, data, level, overflow after the edge.
    add(1, 8'h05, 0, 0, 1, 8'h05, 1, 0);  // single capture, latency 1
    add(0, 8'h06, 1, 0, 0, 8'h00, 0, 0);  // pop back to empty
    add(0, 8'h06, 1, 0, 0, 8'h00, 0, 0);  // empty with ready: nothing moves
    for (int i = 0; i < 3; i++) begin      // idle counter: events ignored
      add(1, 8'h00, 0, 0, 0, 8'h00, 0, 0);
      add(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    end
    add(1, 8'h10, 0, 0, 1, 8'h10, 1, 0);  // fill
    add(0, 8'h11, 0, 0, 1, 8'h10, 1, 0);
    add(1, 8'h12, 0, 0, 1, 8'h10, 2, 0);
    add(0, 8'h13, 0, 0, 1, 8'h10, 2, 0);
    add(1, 8'h14, 0, 0, 1, 8'h10, 3, 0);
    add(0, 8'h15, 0, 0, 1, 8'h10, 3, 0);
    add(1, 8'h16, 0, 0, 1, 8'h10, 4, 0);
    add(0, 8'h17, 0, 0, 1, 8'h10, 4, 0);
    add(1, 8'h18, 0, 0, 1, 8'h10, 4, 1);  // dropped: overflow
    add(0, 8'h19, 0, 0, 1, 8'h10, 4, 1);
    add(1, 8'h30, 1, 0, 1, 8'h12, 4, 1);  // full + pop + push
    add(0, 8'h31, 1, 0, 1, 8'h14, 3, 1);  // drain
    add(0, 8'h31, 1, 0, 1, 8'h16, 2, 1);
    add(0, 8'h31, 1, 0, 1, 8'h30, 1, 1);
    add(0, 8'h31, 1, 0, 0, 8'h00, 0, 1);
    add(0, 8'h31, 0, 1, 0, 8'h00, 0, 0);  // clear without drop
    add(1, 8'h20, 0, 0, 1, 8'h20, 1, 0);  // refill
    add(0, 8'h21, 0, 0, 1, 8'h20, 1, 0);
    add(1, 8'h22, 0, 0, 1, 8'h20, 2, 0);
    add(0, 8'h23, 0, 0, 1, 8'h20, 2, 0);
    add(1, 8'h24, 0, 0, 1, 8'h20, 3, 0);
    add(0, 8'h25, 0, 0, 1, 8'h20, 3, 0);
    add(1, 8'h26, 0, 0, 1, 8'h20, 4, 0);
    add(0, 8'h27, 0, 0, 1, 8'h20, 4, 0);
    add(1, 8'h28, 0, 1, 1, 8'h20, 4, 1);  // drop and clear together: set wins
    add(0, 8'h29, 1, 0, 1, 8'h22, 3, 1);
    add(1, 8'h40, 0, 0, 1, 8'h22, 4, 1);  // held-high event: one capture only
    add(1, 8'h41, 0, 0, 1, 8'h22, 4, 1);
    add(1, 8'h42, 0, 0, 1, 8'h22, 4, 1);
    add(0, 8'h43, 1, 0, 1, 8'h24, 3, 1);
    add(0, 8'h43, 1, 0, 1, 8'h26, 2, 1);
    add(0, 8'h43, 1, 0, 1, 8'h40, 1, 1);
    add(0, 8'h43, 1, 0, 0, 8'h00, 0, 1);
    add(0, 8'h43, 0, 1, 0, 8'h00, 0, 0);

    do_reset(2, "reset");

    foreach (vecs[i]) begin
      step(vecs[i].ev, vecs[i].cnt, vecs[i].rdy, vecs[i].clr);
      cmp_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data, vecs[i].e_level, vecs[i].e_ovf);
      $display("vec %0d: ev=%0b cnt=%02h rdy=%0b clr=%0b -> valid=%0b data=%02h level=%0d ovf=%0b",
               i, vecs[i].ev, vecs[i].cnt, vecs[i].rdy, vecs[i].clr, ts_valid, ts_data, level, overflow);
    end

    // Interleaved push/pop of 10 events: pointers wrap more than twice.
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      cmp_out($sformatf("wrap_push%0d", i), 1'b1, 8'(i), 3'd1, 1'b0);
      step(1'b0, 8'(i), 1'b1, 1'b0);
      cmp_out($sformatf("wrap_pop%0d", i), 1'b0, 8'h00, 3'd0, 1'b0);
      $display("wrap %0d: popped 0x%02h", i, i);
    end

    // Reset mid-operation discards queued entries and the overflow flag.
    for (int i = 0; i < 6; i++) step(i[0] ? 1'b0 : 1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h60, 1'b0, 1'b0);
    step(1'b0, 8'h61, 1'b0, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b0);
    cmp_model("pre_reset");
    do_reset(1, "mid_reset");
    // event_in high after reset counts as a rising edge because history was cleared.
    step(1'b1, 8'h70, 1'b0, 1'b0);
    cmp_out("post_reset", 1'b1, 8'h70, 3'd1, 1'b0);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 2000; n++) begin
      logic          ev, rdy, clr;
      logic [DW-1:0] cnt;
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1, "rand_reset");
        $display("rand %0d: reset", n);
        continue;
      end
      ev  = 1'($urandom_range(0, 1));
      cnt = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      rdy = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 15) == 0);
      step(ev, cnt, rdy, clr);
      cmp_model($sformatf("rand%0d", n));
      $display("rand %0d: ev=%0b cnt=%02h rdy=%0b clr=%0b -> valid=%0b data=%02h level=%0d ovf=%0b",
               n, ev, cnt, rdy, clr, ts_valid, ts_data, level, overflow);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
